hv_fold_scheduler: RTL

- Sequences the folded spatial encoding of one sample across the three modalities, in order GSR (32 ch), ECG (77 ch), EEG (105 ch).
- For each modality × fold × channel it issues one read request to the item/projection memories. It then waits for the encoder's per-fold majority result and emits a fold-write strobe to the fuser buffer.
- Sits between the top-level sample controller and the memories/encoder/fuser.

---
 rtl/hv_sched_pkg.sv | 40 ++++
 rtl/hv_sched_counter.sv | 80 ++++++++
 rtl/hv_fold_scheduler.sv | 133 +++++++++++++
 3 files changed

// File: rtl/hv_sched_pkg.sv
// Shared types and constants for the folded hypervector encoding scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// modality_t matches the encoder's own state encoding, so codes travel unchanged
// on the rd_modality / fold_wr_modality buses.
package hv_sched_pkg;

  localparam int CHANNEL_WIDTH   = 7;
  localparam int GSR_NUM_CHANNEL = 32;
  localparam int ECG_NUM_CHANNEL = 77;
  localparam int EEG_NUM_CHANNEL = 105;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GSR  = 2'b01,
    ECG  = 2'b11,
    EEG  = 2'b10
  } modality_t;

  // Channel count of a modality; IDLE has no channels.
  function automatic logic [CHANNEL_WIDTH-1:0] num_channels(input modality_t m);
    case (m)
      GSR:     return CHANNEL_WIDTH'(GSR_NUM_CHANNEL);
      ECG:     return CHANNEL_WIDTH'(ECG_NUM_CHANNEL);
      EEG:     return CHANNEL_WIDTH'(EEG_NUM_CHANNEL);
      default: return '0;
    endcase
  endfunction

  // Encoding order GSR -> ECG -> EEG; stepping past EEG parks the counter at IDLE.
  function automatic modality_t next_modality(input modality_t m);
    case (m)
      GSR:     return ECG;
      ECG:     return EEG;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/hv_sched_counter.sv
// Nested modality/fold/channel counter for the fold scheduler.
// Latency: state updates one cycle after an advance strobe; last flags are combinational.
// Backpressure: none of its own; it only moves when the parent strobes chan_adv_i/fold_adv_i.
//
// Ports: clk/rst; init_i loads GSR/fold 0/channel 0; abort_i clears everything to 0;
// chan_adv_i steps the channel (wraps to 0 on the modality's last channel);
// fold_adv_i steps fold, then modality (EEG's last fold returns to IDLE/0/0);
// modality_o/channel_o/fold_o current position; *_last_o position flags.
module hv_sched_counter
  import hv_sched_pkg::*;
#(
  parameter int NUM_FOLDS       = 1,
  parameter int NUM_FOLDS_WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       init_i,
  input  logic                       abort_i,
  input  logic                       chan_adv_i,
  input  logic                       fold_adv_i,
  output modality_t                  modality_o,
  output logic [CHANNEL_WIDTH-1:0]   channel_o,
  output logic [NUM_FOLDS_WIDTH-1:0] fold_o,
  output logic                       chan_last_o,
  output logic                       fold_last_o,
  output logic                       mod_last_o
);

  modality_t                  modality_q, modality_d;
  logic [CHANNEL_WIDTH-1:0]   channel_q, channel_d;
  logic [NUM_FOLDS_WIDTH-1:0] fold_q, fold_d;

  // Full-width compares so no counter can run past its limit.
  assign chan_last_o = (channel_q == num_channels(modality_q) - CHANNEL_WIDTH'(1));
  assign fold_last_o = (fold_q == NUM_FOLDS_WIDTH'(NUM_FOLDS - 1));
  assign mod_last_o  = (modality_q == EEG);

  always_comb begin
    modality_d = modality_q;
    channel_d  = channel_q;
    fold_d     = fold_q;
    if (abort_i) begin
      modality_d = IDLE;
      channel_d  = '0;
      fold_d     = '0;
    end else if (init_i) begin
      modality_d = GSR;
      channel_d  = '0;
      fold_d     = '0;
    end else if (fold_adv_i) begin
      channel_d = '0;
      if (!fold_last_o) begin
        fold_d = fold_q + NUM_FOLDS_WIDTH'(1);
      end else begin
        // With NUM_FOLDS=1 this branch is always taken, so the fold stays 0.
        fold_d     = '0;
        modality_d = next_modality(modality_q);
      end
    end else if (chan_adv_i) begin
      channel_d = chan_last_o ? '0 : channel_q + CHANNEL_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      modality_q <= IDLE;
      channel_q  <= '0;
      fold_q     <= '0;
    end else begin
      modality_q <= modality_d;
      channel_q  <= channel_d;
      fold_q     <= fold_d;
    end
  end

  assign modality_o = modality_q;
  assign channel_o  = channel_q;
  assign fold_o     = fold_q;

endmodule

// File: rtl/hv_fold_scheduler.sv
// Sequences one sample's folded spatial encoding: GSR, ECG, EEG x fold x channel reads,
// then one fuser fold write per encoder majority result.
// Latency: start fire to done = reads + WAIT_HV cycles + 1 (min 217*NUM_FOLDS + 1).
// Backpressure: rd_ready low freezes counters and rd_* outputs; WAIT_HV holds until enc_hv_valid.
//
// Ports: start_valid/start_ready sample handshake (ready only in IDLE);
// rd_valid/rd_ready + rd_modality/rd_channel/rd_fold memory read request;
// enc_hv_valid encoder result pulse; fold_wr_en/_modality/_fold fuser write (same cycle
// as enc_hv_valid); busy (not IDLE); done (one cycle after the final EEG fold write).
// Optional macro HV_SCHED_TIMEOUT_EN adds timeout_err and a WAIT_HV watchdog of
// TIMEOUT_CYCLES cycles that aborts the sample back to IDLE.
module hv_fold_scheduler
  import hv_sched_pkg::*;
#(
  parameter int NUM_FOLDS       = 1,
  parameter int NUM_FOLDS_WIDTH = 1,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef HV_SCHED_TIMEOUT_EN
  output logic                       timeout_err,
`endif
  input  logic                       start_valid,
  output logic                       start_ready,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [1:0]                 rd_modality,
  output logic [CHANNEL_WIDTH-1:0]   rd_channel,
  output logic [NUM_FOLDS_WIDTH-1:0] rd_fold,
  input  logic                       enc_hv_valid,
  output logic                       fold_wr_en,
  output logic [1:0]                 fold_wr_modality,
  output logic [NUM_FOLDS_WIDTH-1:0] fold_wr_fold,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_WAIT_HV = 2'b10,
    ST_DONE    = 2'b11
  } state_t;

  state_t                     state_q;
  modality_t                  cnt_modality;
  logic [CHANNEL_WIDTH-1:0]   cnt_channel;
  logic [NUM_FOLDS_WIDTH-1:0] cnt_fold;
  logic                       chan_last, fold_last, mod_last;
  logic                       start_fire, rd_fire, hv_fire, wd_expire;

  assign start_fire = (state_q == ST_IDLE) && start_valid;
  assign rd_fire    = (state_q == ST_ISSUE) && rd_ready;
  assign hv_fire    = (state_q == ST_WAIT_HV) && enc_hv_valid;

`ifdef HV_SCHED_TIMEOUT_EN
  logic [7:0] wdog_q;
  logic       timeout_err_q;

  // enc_hv_valid on the limit cycle wins over the watchdog.
  assign wd_expire   = (state_q == ST_WAIT_HV) && !enc_hv_valid &&
                       (wdog_q == 8'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign wd_expire             = 1'b0;
`endif

  hv_sched_counter #(
    .NUM_FOLDS       (NUM_FOLDS),
    .NUM_FOLDS_WIDTH (NUM_FOLDS_WIDTH)
  ) u_counter (
    .clk         (clk),
    .rst         (rst),
    .init_i      (start_fire),
    .abort_i     (wd_expire),
    .chan_adv_i  (rd_fire),
    .fold_adv_i  (hv_fire),
    .modality_o  (cnt_modality),
    .channel_o   (cnt_channel),
    .fold_o      (cnt_fold),
    .chan_last_o (chan_last),
    .fold_last_o (fold_last),
    .mod_last_o  (mod_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
`ifdef HV_SCHED_TIMEOUT_EN
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
`ifdef HV_SCHED_TIMEOUT_EN
      // Counter is zero outside WAIT_HV, so it restarts on every entry.
      wdog_q        <= (state_q == ST_WAIT_HV && !wd_expire) ? wdog_q + 8'd1 : 8'd0;
      timeout_err_q <= wd_expire;
`endif
      case (state_q)
        ST_IDLE: begin
          if (start_valid) state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (rd_ready && chan_last) state_q <= ST_WAIT_HV;
        end
        ST_WAIT_HV: begin
          if (enc_hv_valid) begin
            state_q <= (fold_last && mod_last) ? ST_DONE : ST_ISSUE;
          end else if (wd_expire) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign start_ready      = (state_q == ST_IDLE);
  assign busy             = (state_q != ST_IDLE);
  assign done             = (state_q == ST_DONE);
  assign rd_valid         = (state_q == ST_ISSUE);
  assign rd_modality      = cnt_modality;
  assign rd_channel       = cnt_channel;
  assign rd_fold          = cnt_fold;
  // Zero-latency write: the fuser captures the encoder result in the same cycle.
  assign fold_wr_en       = hv_fire;
  assign fold_wr_modality = cnt_modality;
  assign fold_wr_fold     = cnt_fold;

endmodule
